disparity_sweep_ctrl: RTL and testbench

DISPARITY_SWEEP_CTRL -- requirements
Module: disparity_sweep_ctrl

---
 rtl/disparity_sweep_ctrl_if.sv | 26 ++
 rtl/disparity_sweep_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_disparity_sweep_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/disparity_sweep_ctrl_if.sv
// Request/response/pixel handshake bundle between the sweep controller,
// the SSD engine and the downstream disparity sink.
interface disparity_sweep_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_row;
  logic [8:0]  req_col;
  logic [4:0]  req_offset;
  logic        rsp_valid;
  logic [20:0] rsp_ssd_0;
  logic [20:0] rsp_ssd_1;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  DATA_0;
  logic [7:0]  DATA_1;

  modport master (
    output req_valid, req_row, req_col, req_offset, pix_valid, DATA_0, DATA_1,
    input  req_ready, rsp_valid, rsp_ssd_0, rsp_ssd_1, pix_ready
  );

  modport slave (
    input  req_valid, req_row, req_col, req_offset, pix_valid, DATA_0, DATA_1,
    output req_ready, rsp_valid, rsp_ssd_0, rsp_ssd_1, pix_ready
  );
endinterface

// File: rtl/disparity_sweep_ctrl.sv
// Frame sequencer for a stereo disparity search: walks pixel pairs, sweeps the
// disparity range through the SSD engine and emits the scaled best offsets.

module disparity_sweep_lane #(
  parameter int MIN_OFFSET = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        clr,
  input  logic        upd,
  input  logic [4:0]  offset,
  input  logic [20:0] ssd,
  output logic [4:0]  nxt_off
);
  logic [20:0] best;
  logic [4:0]  best_off;
  logic        take;

  // strict compare: on a tie the earlier (lower) offset is kept
  assign take    = upd && (ssd < best);
  assign nxt_off = take ? offset : best_off;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      best     <= '1;
      best_off <= 5'(MIN_OFFSET);
    end else if (clr) begin
      best     <= '1;
      best_off <= 5'(MIN_OFFSET);
    end else if (take) begin
      best     <= ssd;
      best_off <= offset;
    end
  end
endmodule

module disparity_sweep_ctrl #(
  parameter int WIDTH          = 320,
  parameter int HEIGHT         = 240,
  parameter int MIN_OFFSET     = 4,
  parameter int MAX_OFFSET     = 10,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   start,
  disparity_sweep_ctrl_if.master bus,
  output logic                   VSYNC,
  output logic                   HSYNC,
  output logic                   ctrl_done,
  output logic                   busy
);
  localparam int NUM_LANES = 2;
  localparam int MAXD      = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int CNT_W     = (MAXD < 2) ? 1 : $clog2(MAXD);
  localparam logic [7:0] SCALE    = 8'(255 / MAX_OFFSET);
  localparam logic [8:0] COL_LAST = 9'(WIDTH - 2);
  localparam logic [8:0] ROW_LAST = 9'(HEIGHT - 1);
  localparam logic [4:0] MINO     = 5'(MIN_OFFSET);
  localparam logic [4:0] MAXO     = 5'(MAX_OFFSET);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HSYNC, S_ISSUE, S_WAIT, S_EMIT, S_DONE} state_t;

  state_t                           state;
  logic [8:0]                       row, col;
  logic [4:0]                       offset;
  logic [CNT_W-1:0]                 cnt;
  logic                             req_valid_q, pix_valid_q;
  logic [NUM_LANES-1:0][7:0]        data_q;
  logic [NUM_LANES-1:0][20:0]       ssd;
  logic [NUM_LANES-1:0][4:0]        nxt_off;
  logic                             lane_clr, lane_upd;

  function automatic logic [7:0] scale(input logic [4:0] o);
    return 8'({3'd0, o} * SCALE);
  endfunction

  assign ssd[0] = bus.rsp_ssd_0;
  assign ssd[1] = bus.rsp_ssd_1;

  // bests restart for every pixel pair: during the line sync and on each emit handshake
  assign lane_clr = (state == S_HSYNC) || (state == S_EMIT && bus.pix_ready);
  assign lane_upd = (state == S_WAIT) && bus.rsp_valid;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    disparity_sweep_lane #(.MIN_OFFSET(MIN_OFFSET)) u_lane (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .clr     (lane_clr),
      .upd     (lane_upd),
      .offset  (offset),
      .ssd     (ssd[g]),
      .nxt_off (nxt_off[g])
    );
  end

  assign bus.req_valid  = req_valid_q;
  assign bus.req_row    = row;
  assign bus.req_col    = col;
  assign bus.req_offset = offset;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.DATA_0     = data_q[0];
  assign bus.DATA_1     = data_q[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      offset      <= '0;
      cnt         <= '0;
      req_valid_q <= 1'b0;
      pix_valid_q <= 1'b0;
      data_q      <= '0;
      VSYNC       <= 1'b0;
      HSYNC       <= 1'b0;
      ctrl_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_VSYNC;
          VSYNC <= 1'b1;
          busy  <= 1'b1;
          cnt   <= '0;
        end
        S_VSYNC: if (cnt == CNT_W'(START_UP_DELAY - 1)) begin
          state <= S_HSYNC;
          VSYNC <= 1'b0;
          HSYNC <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_HSYNC: if (cnt == CNT_W'(HSYNC_DELAY - 1)) begin
          state       <= S_ISSUE;
          HSYNC       <= 1'b0;
          req_valid_q <= 1'b1;
          offset      <= MINO;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_ISSUE: if (bus.req_ready) begin
          req_valid_q <= 1'b0;
          state       <= S_WAIT;
        end
        S_WAIT: if (bus.rsp_valid) begin
          if (offset < MAXO) begin
            offset      <= offset + 5'd1;
            req_valid_q <= 1'b1;
            state       <= S_ISSUE;
          end else begin
            // last response of the sweep is folded in via the lanes' next-best view
            for (int i = 0; i < NUM_LANES; i++) data_q[i] <= scale(nxt_off[i]);
            pix_valid_q <= 1'b1;
            state       <= S_EMIT;
          end
        end
        S_EMIT: if (bus.pix_ready) begin
          pix_valid_q <= 1'b0;
          if (col < COL_LAST) begin
            col         <= col + 9'd2;
            offset      <= MINO;
            req_valid_q <= 1'b1;
            state       <= S_ISSUE;
          end else if (row < ROW_LAST) begin
            col   <= '0;
            row   <= row + 9'd1;
            HSYNC <= 1'b1;
            cnt   <= '0;
            state <= S_HSYNC;
          end else begin
            ctrl_done <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          ctrl_done <= 1'b0;
          busy      <= 1'b0;
          row       <= '0;
          col       <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_disparity_sweep_ctrl.sv
// Directed + randomized bench for disparity_sweep_ctrl on a tiny 4x2 frame;
// the bench plays SSD engine and pixel sink and predicts DATA from an argmin model.
module tb_disparity_sweep_ctrl;
  localparam int W = 4, H = 2, MIN_O = 4, MAX_O = 10, SU = 3, HS = 2;
  localparam int SC     = 255 / MAX_O;
  localparam int NPIX   = (W / 2) * H;
  localparam int NSWEEP = MAX_O - MIN_O + 1;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic start;
  logic VSYNC, HSYNC, ctrl_done, busy;

  disparity_sweep_ctrl_if bus();

  disparity_sweep_ctrl #(
    .WIDTH(W), .HEIGHT(H), .MIN_OFFSET(MIN_O), .MAX_OFFSET(MAX_O),
    .START_UP_DELAY(SU), .HSYNC_DELAY(HS)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .bus(bus),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .ctrl_done(ctrl_done), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0, errors = 0;
  int vs_n, hs_n, hs_rise, nreq, npix, ndone, pix_idx;
  bit excl_ok, busy_ok, got_done;
  int          q_off[$];
  logic [20:0] q_s0[$];
  logic [20:0] q_s1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // argmin over the sweep, first minimum wins, untouched best stays at MIN_O
  function automatic logic [15:0] ref_pix();
    logic [20:0] bv0, bv1;
    int bo0, bo1;
    bv0 = 21'h1FFFFF; bv1 = 21'h1FFFFF; bo0 = MIN_O; bo1 = MIN_O;
    for (int i = 0; i < q_off.size(); i++) begin
      if (q_s0[i] < bv0) begin bv0 = q_s0[i]; bo0 = q_off[i]; end
      if (q_s1[i] < bv1) begin bv1 = q_s1[i]; bo1 = q_off[i]; end
    end
    return {8'(bo1 * SC), 8'(bo0 * SC)};
  endfunction

  function automatic logic [20:0] gen(input int mode, input int off, input int lane);
    int d;
    case (mode)
      1: begin
        d = (off > 7) ? off - 7 : 7 - off;
        return (lane == 0) ? 21'(d * 100) : 21'd50;
      end
      2: return 21'h1FFFFF;
      default:
        return ($urandom_range(0, 3) == 0) ? 21'($urandom_range(0, 21'h1FFFFF))
                                            : 21'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({VSYNC, HSYNC, ctrl_done, busy, bus.req_valid, bus.pix_valid,
                bus.req_row, bus.req_col, bus.req_offset, bus.DATA_0, bus.DATA_1});
  endfunction

  task automatic run_frame(input int mode, input int req_stall, input int pix_stall,
                           input bit spur, input int abort_pix, output bit aborted);
    bit pend, hs_prev, rstalled, pstalled;
    logic [20:0] p0, p1;
    logic [22:0] held_req, cur_req;
    logic [15:0] held_pix, cur_pix;
    int rs, ps, eoff;
    rs = req_stall; ps = pix_stall; pend = 0; hs_prev = 0; rstalled = 0; pstalled = 0;
    aborted = 0; got_done = 0;
    vs_n = 0; hs_n = 0; hs_rise = 0; nreq = 0; npix = 0; ndone = 0; pix_idx = 0;
    excl_ok = 1; busy_ok = 1;
    q_off.delete(); q_s0.delete(); q_s1.delete();
    p0 = '0; p1 = '0; held_req = '0; held_pix = '0;
    @(negedge HCLK);
    start = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge HCLK);
      start = 1'b0; bus.rsp_valid = 1'b0; bus.req_ready = 1'b0; bus.pix_ready = 1'b0;
      bus.rsp_ssd_0 = '0; bus.rsp_ssd_1 = '0;
      vs_n += int'(VSYNC); hs_n += int'(HSYNC); ndone += int'(ctrl_done);
      if (HSYNC && !hs_prev) hs_rise++;
      hs_prev = HSYNC;
      if ($countones({VSYNC, HSYNC, bus.req_valid, bus.pix_valid, ctrl_done}) > 1) excl_ok = 0;
      if (!busy) busy_ok = 0;
      cur_req = {bus.req_row, bus.req_col, bus.req_offset};
      cur_pix = {bus.DATA_1, bus.DATA_0};
      if (pend) begin
        if (abort_pix == pix_idx && q_off.size() == 1) begin
          HRESETn = 1'b0;
          aborted = 1;
          break;
        end
        bus.rsp_valid = 1'b1; bus.rsp_ssd_0 = p0; bus.rsp_ssd_1 = p1;
        pend = 0;
        if (spur) start = 1'b1;
      end else if (bus.req_valid) begin
        if (rs > 0) begin
          if (!rstalled) held_req = cur_req;
          else chk("req_stable", 64'(cur_req), 64'(held_req));
          rstalled = 1; rs--;
        end else begin
          if (rstalled) begin chk("req_stable_accept", 64'(cur_req), 64'(held_req)); rstalled = 0; end
          eoff = MIN_O + q_off.size();
          chk("req_fields", 64'(cur_req),
              64'({9'(pix_idx / (W / 2)), 9'(2 * (pix_idx % (W / 2))), 5'(eoff)}));
          bus.req_ready = 1'b1;
          p0 = gen(mode, eoff, 0); p1 = gen(mode, eoff, 1);
          q_off.push_back(eoff); q_s0.push_back(p0); q_s1.push_back(p1);
          pend = 1; nreq++;
          if (spur) bus.rsp_valid = 1'b1;
        end
      end else if (bus.pix_valid) begin
        if (ps > 0) begin
          if (!pstalled) held_pix = cur_pix;
          else chk("pix_stable", 64'(cur_pix), 64'(held_pix));
          pstalled = 1; ps--;
        end else begin
          if (pstalled) begin chk("pix_stable_accept", 64'(cur_pix), 64'(held_pix)); pstalled = 0; end
          chk("pix_data", 64'(cur_pix), 64'(ref_pix()));
          if (mode == 1) chk("min_search", 64'(cur_pix), 64'({8'd100, 8'd175}));
          if (mode == 2) chk("saturation", 64'(cur_pix), 64'({8'd100, 8'd100}));
          bus.pix_ready = 1'b1;
          q_off.delete(); q_s0.delete(); q_s1.delete();
          pix_idx++; npix++;
          if (spur) bus.rsp_valid = 1'b1;
        end
      end
      if (ctrl_done) begin got_done = 1; break; end
    end
    if (!aborted) chk("frame_done_seen", 64'(got_done), 64'd1);
  endtask

  task automatic frame_checks();
    chk("vsync_cycles", 64'(vs_n), 64'(SU));
    chk("hsync_cycles", 64'(hs_n), 64'(HS * H));
    chk("hsync_lines", 64'(hs_rise), 64'(H));
    chk("req_count", 64'(nreq), 64'(NPIX * NSWEEP));
    chk("pix_count", 64'(npix), 64'(NPIX));
    chk("done_pulses", 64'(ndone), 64'd1);
    chk("exclusive", 64'(excl_ok), 64'd1);
    chk("busy_in_frame", 64'(busy_ok), 64'd1);
    @(negedge HCLK);
    chk("idle_after_done", 64'({busy, ctrl_done, bus.req_row, bus.req_col}), 64'd0);
  endtask

  initial begin
    bit ab;
    HRESETn = 1'b0; start = 1'b0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.pix_ready = 1'b0;
    bus.rsp_ssd_0 = '0; bus.rsp_ssd_1 = '0;
    repeat (3) @(negedge HCLK);
    chk("reset_outputs", out_vec(), 64'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("idle_ignores_nothing", 64'(busy), 64'd0);

    run_frame(1, 0, 0, 0, -1, ab); frame_checks();   // timing + minimum search
    run_frame(0, 5, 4, 0, -1, ab); frame_checks();   // backpressure
    run_frame(0, 0, 0, 1, -1, ab); frame_checks();   // spurious rsp_valid / start
    run_frame(2, 0, 0, 0, -1, ab); frame_checks();   // saturated responses

    run_frame(0, 0, 0, 0, 3, ab);                    // reset mid-WAIT at row 1 col 2
    chk("abort_reached", 64'(ab), 64'd1);
    #1;
    chk("reset_midframe", out_vec(), 64'd0);
    @(negedge HCLK);
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.pix_ready = 1'b0;
    chk("reset_held_idle", out_vec(), 64'd0);
    HRESETn = 1'b1;
    run_frame(0, 0, 0, 0, -1, ab); frame_checks();

    for (int k = 0; k < 3; k++) begin
      run_frame(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, ab);
      frame_checks();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
